// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for a multicycle MIPS-style datapath
// Memory states (FETCH, MEMRD, MEMWR) stretch by MEM_WAIT cycles via a shared wait counter.
module multicycle_control #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       illegal,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RCOMP  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic       illegal;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;
  logic       wait_last;
  ctrl_t      ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wait_last = (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d = S_FETCH;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        state_d        = S_FETCH;
        if (wait_last) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            ctrl.illegal = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        state_d       = wait_last ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        state_d        = wait_last ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
        state_d        = S_RCOMP;
      end
      S_RCOMP: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        state_d            = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
        state_d        = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Counter only advances while a memory state holds itself; any entry or exit clears it.
  always_comb begin
    wait_cnt_d = 4'd0;
    if ((state_d == state_q) &&
        (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  assign {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
          ALUSrcA, RegWrite, RegDst, illegal, PCSource, ALUOp, ALUSrcB} =
         reset ? '0 : ctrl;
  assign state = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed table-driven bench for multicycle_control
// Three instances cover MEM_WAIT = 0, 2 and 3.
module tb_multicycle_control;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [16:0] ctl;
    string       name;
  } vec_t;

  localparam logic [5:0] RT = 6'b000000;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100;
  localparam logic [5:0] JP = 6'b000010;
  localparam logic [5:0] AI = 6'b001000;
  localparam logic [5:0] XX = 6'b111111;

  // {PCW PCWC IorD MR _ MW M2R IRW ASA _ RW RD ILL, PCSource, ALUOp, ALUSrcB}
  localparam logic [16:0] K_ZERO = '0;
  localparam logic [16:0] K_F0   = {11'b0001_0000_000, 2'b00, 2'b00, 2'b01};
  localparam logic [16:0] K_FL   = {11'b1001_0010_000, 2'b00, 2'b00, 2'b01};
  localparam logic [16:0] K_DEC  = {11'b0000_0000_000, 2'b00, 2'b00, 2'b11};
  localparam logic [16:0] K_DILL = {11'b0000_0000_001, 2'b00, 2'b00, 2'b11};
  localparam logic [16:0] K_MADR = {11'b0000_0001_000, 2'b00, 2'b00, 2'b10};
  localparam logic [16:0] K_MRD  = {11'b0011_0000_000, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] K_MWB  = {11'b0000_0100_100, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] K_MWR  = {11'b0010_1000_000, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] K_EXEC = {11'b0000_0001_000, 2'b00, 2'b10, 2'b00};
  localparam logic [16:0] K_RCMP = {11'b0000_0000_110, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] K_BR   = {11'b0100_0001_000, 2'b01, 2'b01, 2'b00};
  localparam logic [16:0] K_JMP  = {11'b1000_0000_000, 2'b10, 2'b00, 2'b00};
  localparam logic [16:0] K_AEX  = {11'b0000_0001_000, 2'b00, 2'b00, 2'b10};
  localparam logic [16:0] K_AWB  = {11'b0000_0000_100, 2'b00, 2'b00, 2'b00};

  logic        clk;
  logic        rst_v [3];
  logic [5:0]  op_v  [3];
  logic [16:0] ctl_w [3];
  logic [3:0]  st_w  [3];

  int total;
  int bad;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, ill;
    logic [1:0] pcs, aop, asb;
    logic [3:0] st;

    multicycle_control #(.MEM_WAIT((g == 0) ? 0 : (g == 1) ? 2 : 3)) dut (
      .clk        (clk),
      .reset      (rst_v[g]),
      .op         (op_v[g]),
      .PCWrite    (pcw),
      .PCWriteCond(pcwc),
      .IorD       (iord),
      .MemRead    (mr),
      .MemWrite   (mw),
      .MemtoReg   (m2r),
      .IRWrite    (irw),
      .ALUSrcA    (asa),
      .RegWrite   (rw),
      .RegDst     (rd),
      .illegal    (ill),
      .PCSource   (pcs),
      .ALUOp      (aop),
      .ALUSrcB    (asb),
      .state      (st)
    );

    assign ctl_w[g] = {pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, ill, pcs, aop, asb};
    assign st_w[g]  = st;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs after the falling edge, then check the Moore outputs.
  task automatic step(input int d, input logic rst, input logic [5:0] op,
                      input logic [3:0] est, input logic [16:0] ectl, input string name);
    @(negedge clk);
    rst_v[d] = rst;
    op_v[d]  = op;
    #1;
    total++;
    if (st_w[d] !== est || ctl_w[d] !== ectl) begin
      bad++;
      $display("FAIL %s (dut%0d): state=%0d ctl=%05h, expected state=%0d ctl=%05h",
               name, d, st_w[d], ctl_w[d], est, ectl);
    end
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [5:0] op, logic [3:0] st,
                              logic [16:0] ctl, string name);
    vec_t v;
    v.rst = rst; v.op = op; v.st = st; v.ctl = ctl; v.name = name;
    return v;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1;
      op_v[i]  = 6'b0;
    end

    tbl.push_back(mk(1, LW, 0,  K_ZERO, "reset"));
    tbl.push_back(mk(0, LW, 0,  K_FL,   "lw_fetch"));
    tbl.push_back(mk(0, LW, 1,  K_DEC,  "lw_decode"));
    tbl.push_back(mk(0, LW, 2,  K_MADR, "lw_memadr"));
    tbl.push_back(mk(0, LW, 3,  K_MRD,  "lw_memrd"));
    tbl.push_back(mk(0, LW, 4,  K_MWB,  "lw_memwb"));
    tbl.push_back(mk(0, SW, 0,  K_FL,   "sw_fetch"));
    tbl.push_back(mk(0, SW, 1,  K_DEC,  "sw_decode"));
    tbl.push_back(mk(0, SW, 2,  K_MADR, "sw_memadr"));
    tbl.push_back(mk(0, SW, 5,  K_MWR,  "sw_memwr"));
    tbl.push_back(mk(0, RT, 0,  K_FL,   "r_fetch"));
    tbl.push_back(mk(0, RT, 1,  K_DEC,  "r_decode"));
    tbl.push_back(mk(0, RT, 6,  K_EXEC, "r_exec"));
    tbl.push_back(mk(0, RT, 7,  K_RCMP, "r_rcomp"));
    tbl.push_back(mk(0, AI, 0,  K_FL,   "addi_fetch"));
    tbl.push_back(mk(0, AI, 1,  K_DEC,  "addi_decode"));
    tbl.push_back(mk(0, AI, 10, K_AEX,  "addi_ex"));
    tbl.push_back(mk(0, AI, 11, K_AWB,  "addi_wb"));
    tbl.push_back(mk(0, BQ, 0,  K_FL,   "beq_fetch"));
    tbl.push_back(mk(0, BQ, 1,  K_DEC,  "beq_decode"));
    tbl.push_back(mk(0, BQ, 8,  K_BR,   "beq_branch"));
    tbl.push_back(mk(0, JP, 0,  K_FL,   "j_fetch"));
    tbl.push_back(mk(0, JP, 1,  K_DEC,  "j_decode"));
    tbl.push_back(mk(0, JP, 9,  K_JMP,  "j_jump"));
    tbl.push_back(mk(0, XX, 0,  K_FL,   "ill_fetch"));
    tbl.push_back(mk(0, XX, 1,  K_DILL, "ill_decode"));
    tbl.push_back(mk(0, LW, 0,  K_FL,   "ill_refetch"));
    tbl.push_back(mk(0, LW, 1,  K_DEC,  "lw2_decode"));
    tbl.push_back(mk(0, LW, 2,  K_MADR, "lw2_memadr"));
    tbl.push_back(mk(1, LW, 0,  K_ZERO, "lw2_reset_in_memrd"));
    tbl.push_back(mk(0, JP, 0,  K_FL,   "post_reset_fetch"));
    tbl.push_back(mk(0, JP, 1,  K_DEC,  "post_reset_decode"));
    tbl.push_back(mk(0, JP, 9,  K_JMP,  "post_reset_jump"));
    tbl.push_back(mk(0, JP, 0,  K_FL,   "final_fetch"));

    for (int i = 0; i < tbl.size(); i++)
      step(0, tbl[i].rst, tbl[i].op, tbl[i].st, tbl[i].ctl, tbl[i].name);
    rst_v[0] = 1'b1;

    // MEM_WAIT=2, R-type: fetch held three cycles, IR/PC written only in the last.
    step(1, 1, RT, 0, K_ZERO, "w2_reset");
    step(1, 0, RT, 0, K_F0,   "w2_fetch0");
    step(1, 0, RT, 0, K_F0,   "w2_fetch1");
    step(1, 0, RT, 0, K_FL,   "w2_fetch2");
    step(1, 0, RT, 1, K_DEC,  "w2_decode");
    step(1, 0, RT, 6, K_EXEC, "w2_exec");
    step(1, 0, RT, 7, K_RCMP, "w2_rcomp");
    step(1, 0, RT, 0, K_F0,   "w2_refetch0");
    rst_v[1] = 1'b1;

    // MEM_WAIT=3, lw interrupted by reset in MEMRD cycle 1; fetch must restart at count 0.
    step(2, 1, LW, 0, K_ZERO, "w3_reset");
    step(2, 0, LW, 0, K_F0,   "w3_fetch0");
    step(2, 0, LW, 0, K_F0,   "w3_fetch1");
    step(2, 0, LW, 0, K_F0,   "w3_fetch2");
    step(2, 0, LW, 0, K_FL,   "w3_fetch3");
    step(2, 0, LW, 1, K_DEC,  "w3_decode");
    step(2, 0, LW, 2, K_MADR, "w3_memadr");
    step(2, 0, LW, 3, K_MRD,  "w3_memrd0");
    step(2, 1, LW, 0, K_ZERO, "w3_reset_memrd1");
    step(2, 0, LW, 0, K_F0,   "w3_restart0");
    step(2, 0, LW, 0, K_F0,   "w3_restart1");
    step(2, 0, LW, 0, K_F0,   "w3_restart2");
    step(2, 0, LW, 0, K_FL,   "w3_restart3");
    step(2, 0, LW, 1, K_DEC,  "w3_redecode");
    step(2, 0, LW, 2, K_MADR, "w3_rememadr");
    step(2, 0, LW, 3, K_MRD,  "w3_rememrd0");
    step(2, 0, LW, 3, K_MRD,  "w3_rememrd1");
    step(2, 0, LW, 3, K_MRD,  "w3_rememrd2");
    step(2, 0, LW, 3, K_MRD,  "w3_rememrd3");
    step(2, 0, LW, 4, K_MWB,  "w3_memwb");
    step(2, 0, LW, 0, K_F0,   "w3_next_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_WAIT, default 0, number of extra wait cycles held in every memory-access state (0..15).
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: op  input  6  opcode field from the instruction register.
REQ-005 Port outputs, 1 bit each: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, illegal.
REQ-006 Port outputs, 2 bits each: PCSource (00 ALU, 01 ALUOut, 10 jump target), ALUOp (00 add, 01 sub, 10 funct), ALUSrcB (00 reg B, 01 const 4, 10 sign-ext, 11 sign-ext<<2).
REQ-007 Port: state  output  4  current FSM state code, for debug and bench.

Function
REQ-008 The block SHALL be a Moore FSM; every control output SHALL be a pure function of state and wait counter.
REQ-009 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 unused.
REQ-010 Supported opcodes SHALL be: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-011 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=1 and PCWrite=1 only in the final cycle of FETCH.
REQ-012 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00; then branch on op: lw/sw->MEMADR, R-type->EXEC, beq->BRANCH, j->JUMP, addi->ADDIEX.
REQ-013 An undefined op in DECODE SHALL transition to FETCH and assert illegal for exactly that one DECODE cycle.
REQ-014 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD if op=lw, else MEMWR.
REQ-015 MEMRD SHALL drive MemRead=1, IorD=1; after its final cycle, go to MEMWB.
REQ-016 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
REQ-017 MEMWR SHALL drive MemWrite=1, IorD=1; after its final cycle, go to FETCH.
REQ-018 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10; next RCOMP.
REQ-019 RCOMP SHALL drive RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
REQ-020 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next FETCH.
REQ-021 JUMP SHALL drive PCWrite=1, PCSource=10; next FETCH.
REQ-022 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDIWB; ADDIWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0, then go to FETCH.
REQ-023 Outputs not listed for a state SHALL be 0.
REQ-024 A 4-bit wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR, and SHALL increment each cycle spent there.
REQ-025 Those memory states SHALL therefore last MEM_WAIT+1 cycles; the final cycle is the one where the counter equals MEM_WAIT.
REQ-026 MemRead/MemWrite SHALL stay asserted for every cycle of their memory state; IRWrite/PCWrite SHALL never be asserted in non-final FETCH cycles.
REQ-027 Instruction cycle counts with MEM_WAIT=0 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-028 An unused state code, however reached, SHALL transition to FETCH on the next edge with all outputs 0.

Reset
REQ-029 While reset=1 at a rising edge, the next state SHALL be FETCH and the wait counter SHALL be 0.
REQ-030 While reset is high, all control outputs and illegal SHALL be forced to 0, and state SHALL read 0.
REQ-031 Reset SHALL take priority over every transition, including mid-instruction and mid-wait; no partial write SHALL be issued after reset is sampled.
REQ-032 The first cycle after reset deasserts SHALL be cycle 0 of FETCH.

Verification
REQ-033 MEM_WAIT=0, op=100011 (lw) after reset -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-034 MEM_WAIT=0, op=101011 (sw) -> sequence 0,1,2,5,0; MemWrite=1 for exactly one cycle, IorD=1 in that same cycle.
REQ-035 MEM_WAIT=2, op=000000 -> FETCH lasts 3 cycles, with IRWrite=PCWrite=1 only in the 3rd; then states 1,6,7,0.
REQ-036 op=000100 then op=000010 -> BRANCH asserts PCWriteCond=1 with ALUOp=01; JUMP asserts PCWrite=1 with PCSource=10.
REQ-037 op=111111 -> illegal=1 for exactly one cycle in state 1, next state 0, and no RegWrite/MemWrite pulse.
REQ-038 MEM_WAIT=3, reset asserted during cycle 1 of MEMRD -> next state 0, all outputs 0 while reset is high, and FETCH restarts with counter 0.
